// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer
//   FIFO write-back buffer between L2 and DataMemory. Dirty-eviction words are
//   queued without stalling L2 on the memory write latency, and drained in
//   order. Buffered entries are forwarded to L2 fill lookups (youngest match
//   wins). A flush request blocks new evictions until the buffer has drained.
//
//   Optional build macro WB_COALESCE_EN: an eviction whose address matches a
//   stored, not-in-flight entry overwrites that entry's data in place.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   evict_valid/addr/data/ready   eviction push from L2
//   fill_addr, fill_hit/data      combinational forwarding lookup
//   dmem_wr_en/addr/data, dmem_ack  write channel to DataMemory
//   flush, flush_done             drain request / completion pulse
//   count, empty, full            occupancy status
module l2_writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       evict_valid,
    input  logic [ADDR_W-1:0]          evict_addr,
    input  logic [DATA_W-1:0]          evict_data,
    output logic                       evict_ready,
    input  logic [ADDR_W-1:0]          fill_addr,
    output logic                       fill_hit,
    output logic [DATA_W-1:0]          fill_data,
    output logic                       dmem_wr_en,
    output logic [ADDR_W-1:0]          dmem_addr,
    output logic [DATA_W-1:0]          dmem_data,
    input  logic                       dmem_ack,
    input  logic                       flush,
    output logic                       flush_done,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic {IDLE, WRITE} state_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] slot [DEPTH];   // slot[i] = storage index of i-th oldest entry
    logic [CW-1:0] count_q, count_nxt;
    state_t        state;
    logic          flush_pending;
    logic          push, push_app, pop, coal_hit, done_nxt;
    logic [PW-1:0] coal_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) slot[i] = rd_ptr + PW'(i);
    end

    // Oldest-to-youngest scan so the last match (youngest) overrides.
    always_comb begin
        fill_hit  = 1'b0;
        fill_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && mem[slot[i]].addr == fill_addr) begin
                fill_hit  = 1'b1;
                fill_data = mem[slot[i]].data;
            end
        end
    end

`ifdef WB_COALESCE_EN
    // The in-flight head is excluded so data presented to DataMemory stays stable.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && !(i == 0 && state == WRITE) &&
                mem[slot[i]].addr == evict_addr) begin
                coal_hit = 1'b1;
                coal_idx = slot[i];
            end
        end
    end
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign evict_ready = !flush_pending && (!full || coal_hit);
    assign push        = evict_valid && evict_ready;
    assign push_app    = push && !coal_hit;
    assign pop         = (state == WRITE) && dmem_ack;
    assign count_nxt   = count_q + CW'(push_app) - CW'(pop);
    // A push racing a flush on an empty buffer must still be drained first.
    assign done_nxt    = (flush_pending || flush) && empty && (state == IDLE) && !push;

    assign dmem_wr_en  = (state == WRITE);
    assign dmem_addr   = dmem_wr_en ? mem[rd_ptr].addr : '0;
    assign dmem_data   = dmem_wr_en ? mem[rd_ptr].data : '0;

    // Storage carries no reset; validity is defined purely by count/pointers.
    always_ff @(posedge clk) begin
        if (push_app)  mem[wr_ptr]        <= '{addr: evict_addr, data: evict_data};
        else if (push) mem[coal_idx].data <= evict_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            state         <= IDLE;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            if (push_app) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_nxt;
            case (state)
                // Including the current push lets a word go out the cycle after it lands.
                IDLE:    if (!empty || push_app) state <= WRITE;
                WRITE:   if (dmem_ack && count_q <= CW'(1)) state <= IDLE;
                default: state <= IDLE;
            endcase
            flush_done    <= done_nxt;
            flush_pending <= done_nxt ? 1'b0 : (flush_pending || flush);
        end
    end
endmodule
